// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the MDU_op encodings, the FSM state type and the default latencies.
package e_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide datapath: produces the full {hi,lo} result for
// one operand pair plus a divide-by-zero flag.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Division works on magnitudes so 0x80000000 / -1 cannot overflow the
  // signed divider; signs are restored afterwards.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    result      = '0;
    div_by_zero = 1'b0;

    a_ext   = (op == MDU_MULT) ? {{32{a[31]}}, a} : {32'b0, a};
    b_ext   = (op == MDU_MULT) ? {{32{b[31]}}, b} : {32'b0, b};
    product = a_ext * b_ext;

    a_neg   = (op == MDU_DIV) && a[31];
    b_neg   = (op == MDU_DIV) && b[31];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    divisor = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;

    case (op)
      MDU_MULT, MDU_MULTU: result = product;
      MDU_DIV, MDU_DIVU: begin
        result      = {rem, quot};
        div_by_zero = (b == 32'd0);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: latency-modelling FSM, pending result
// registers and the architectural HI/LO pair.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] phi_q, plo_q;
  logic        pdbz_q;
  logic [31:0] hi_q, lo_q;

  logic [63:0] calc_result;
  logic        calc_dbz;
  logic        idle;
  logic        accept;
  logic        done;

  e_mdu_calc u_calc (
    .op         (MDU_op),
    .a          (A),
    .b          (B),
    .result     (calc_result),
    .div_by_zero(calc_dbz)
  );

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle && Start && is_muldiv(MDU_op);
  assign done   = (state_q == ST_BUSY) && (cnt_q == 4'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (done)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // Pending results are cleared on reset too, so an abandoned operation can
  // never leak into HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      pdbz_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (accept) begin
      cnt_q  <= is_div(MDU_op) ? DIV_CNT : MULT_CNT;
      phi_q  <= calc_result[63:32];
      plo_q  <= calc_result[31:0];
      pdbz_q <= calc_dbz;
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q - 4'd1;
      if (done && !pdbz_q) begin
        hi_q <= phi_q;
        lo_q <= plo_q;
      end
    end else if (Start && idle) begin
      if (MDU_op == MDU_MTHI) hi_q <= A;
      if (MDU_op == MDU_MTLO) lo_q <= A;
    end
  end

  assign Busy = (state_q == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: expected HI/LO and busy length are queued
// when an operation is issued and compared when Busy falls.
module tb_e_mdu;
  import e_mdu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDU_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDU_op(MDU_op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  // Called at a negedge; drives one Start strobe and returns at the next negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start  = 1'b1;
    MDU_op = op;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
    Start  = 1'b0;
    MDU_op = MDU_NONE;
    @(negedge clk);
  endtask

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int cycles);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.cycles = cycles;
    sb_q.push_back(e);
  endtask

  // Scoreboard consumer: counts Busy cycles (bounded) and checks HI/LO after Busy falls.
  task automatic collect(input int already);
    exp_t e;
    int   n = already;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got completion, required a queued expectation");
      return;
    end
    e = sb_q.pop_front();
    total++;
    if (n !== e.cycles) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", e.name, n, e.cycles);
    end
    total++;
    if (HI !== e.hi) begin
      bad++;
      $display("FAIL %s_hi: got %h, required %h", e.name, HI, e.hi);
    end
    total++;
    if (LO !== e.lo) begin
      bad++;
      $display("FAIL %s_lo: got %h, required %h", e.name, LO, e.lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; Start = 1'b0; MDU_op = MDU_NONE; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(MDU_MTHI, 32'h1234_5678, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({Busy, HI, LO} !== 65'h0) begin
      bad++;
      $display("FAIL reset_async: got busy=%b hi=%h lo=%h, required all zero", Busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({Busy, HI, LO} !== 65'h0) begin
        bad++;
        $display("FAIL reset_idle_%0d: got busy=%b hi=%h lo=%h, required all zero", i, Busy, HI, LO);
      end
    end
  endtask

  task automatic test_mult;
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    collect(0);
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
    push("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
    collect(0);
  endtask

  task automatic test_div;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    collect(0);
    issue(MDU_DIVU, 32'd7, 32'd2);
    push("divu", 32'd1, 32'd3, 10);
    collect(0);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    push("div_ovf", 32'h0, 32'h8000_0000, 10);
    collect(0);
  endtask

  task automatic test_div_by_zero;
    issue(MDU_MTHI, 32'h1111_1111, 32'h0);
    total++;
    if (HI !== 32'h1111_1111 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL mthi: got hi=%h busy=%b, required hi=11111111 busy=0", HI, Busy);
    end
    issue(MDU_MTLO, 32'h2222_2222, 32'h0);
    total++;
    if (LO !== 32'h2222_2222 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL mtlo: got lo=%h busy=%b, required lo=22222222 busy=0", LO, Busy);
    end
    issue(MDU_DIV, 32'd55, 32'd0);
    push("div_zero", 32'h1111_1111, 32'h2222_2222, 10);
    collect(0);
    issue(MDU_DIVU, 32'd55, 32'd0);
    push("divu_zero", 32'h1111_1111, 32'h2222_2222, 10);
    collect(0);
  endtask

  task automatic test_busy_ignore;
    issue(MDU_MULT, 32'd6, 32'd7);
    push("busy_ign", 32'h0, 32'd42, 5);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_ign_start: got busy=%b, required 1", Busy);
    end
    issue(MDU_MTLO, 32'h0000_DEAD, 32'h0);
    issue(MDU_DIVU, 32'd9, 32'd4);
    collect(2);
    for (int i = 0; i < 12; i++) begin
      total++;
      if (Busy !== 1'b0 || LO !== 32'd42) begin
        bad++;
        $display("FAIL busy_ign_after_%0d: got busy=%b lo=%h, required busy=0 lo=0000002a", i, Busy, LO);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_op;
    issue(MDU_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_busy: got busy=%b, required 1", Busy);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({Busy, HI, LO} !== 65'h0) begin
      bad++;
      $display("FAIL reset_mid_clear: got busy=%b hi=%h lo=%h, required all zero", Busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if ({Busy, HI, LO} !== 65'h0) begin
        bad++;
        $display("FAIL reset_mid_after_%0d: got busy=%b hi=%h lo=%h, required all zero", i, Busy, HI, LO);
      end
    end
  endtask

  task automatic test_back_to_back;
    issue(MDU_MULTU, 32'h0001_0000, 32'h0001_0000);
    push("b2b_mult", 32'h0000_0001, 32'h0, 5);
    collect(0);
    issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
    push("b2b_div", 32'd1, 32'hFFFF_FFFD, 10);
    collect(0);
    issue(MDU_RSVD, 32'h5555_5555, 32'h1);
    total++;
    if (Busy !== 1'b0 || HI !== 32'd1 || LO !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL op_reserved: got busy=%b hi=%h lo=%h, required 0 00000001 fffffffd", Busy, HI, LO);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_busy_ignore();
    test_reset_mid_op();
    test_back_to_back();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
